// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline sequencing controller.
// The latency counter width bounds MUL_LAT/DIV_LAT to 1..15.
package hazard_ctrl_pkg;

  localparam int RSIZE_DEF   = 5;
  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 12;
  localparam int MD_CNT_W    = 4;

  // Pipeline action selected each cycle, highest priority first.
  typedef enum logic [2:0] {
    ACT_RESET  = 3'd0,
    ACT_FREEZE = 3'd1,
    ACT_BRANCH = 3'd2,
    ACT_STALL  = 3'd3,
    ACT_RUN    = 3'd4
  } pipe_act_e;

endpackage

// File: rtl/hazard_ctrl_md_occupancy.sv
// Tracks how long the shared MUL/DIV unit stays occupied after a start pulse.
// The count runs down every cycle, independent of pipeline freezes.
module hazard_ctrl_md_occupancy
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  logic [MD_CNT_W-1:0] md_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= '0;
    end else if (start) begin
      md_cnt <= is_div ? MD_CNT_W'(DIV_LAT) : MD_CNT_W'(MUL_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

  assign busy = (md_cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: picks freeze / branch flush / stall / run
// each cycle and issues the MUL/DIV start strobe.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RSIZE   = RSIZE_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int SCNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RSIZE-1:0]  ID_RAddr1,
  input  logic [RSIZE-1:0]  ID_RAddr2,
  input  logic              ID_Uses1,
  input  logic              ID_Uses2,
  input  logic              ID_MDOp,
  input  logic              ID_MDIsDiv,
  input  logic              ID_HiLoRd,
  input  logic              EX_MemRead,
  input  logic              EX_RFWen,
  input  logic [RSIZE-1:0]  EX_WAddr,
  input  logic              EX_BrTaken,
  input  logic              MEM_Ready,
  output logic              PC_En,
  output logic              IF_ID_En,
  output logic              IF_ID_Flush,
  output logic              ID_EX_En,
  output logic              ID_EX_Flush,
  output logic              EX_MEM_En,
  output logic              MEM_WB_En,
  output logic              MD_Start,
  output logic              MD_IsDiv,
  output logic              MD_Busy,
  output logic [SCNT_W-1:0] StallCnt
);

  pipe_act_e act;
  logic      md_busy_q;
  logic      load_use;
  logic      md_haz;

  hazard_ctrl_md_occupancy #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) u_md_occupancy (
    .clk   (clk),
    .rst_n (rst_n),
    .start (MD_Start),
    .is_div(ID_MDIsDiv),
    .busy  (md_busy_q)
  );

  // A load to r0 never produces a value, so it cannot create a hazard.
  assign load_use = EX_MemRead & EX_RFWen & (EX_WAddr != '0) &
                    ((ID_Uses1 & (ID_RAddr1 == EX_WAddr)) |
                     (ID_Uses2 & (ID_RAddr2 == EX_WAddr)));
  assign md_haz   = md_busy_q & (ID_MDOp | ID_HiLoRd);

  always_comb begin
    act = ACT_RUN;
    if (!rst_n)                  act = ACT_RESET;
    else if (!MEM_Ready)         act = ACT_FREEZE;
    else if (EX_BrTaken)         act = ACT_BRANCH;
    else if (load_use || md_haz) act = ACT_STALL;
  end

  always_comb begin
    PC_En       = 1'b1;
    IF_ID_En    = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_En    = 1'b1;
    ID_EX_Flush = 1'b0;
    EX_MEM_En   = 1'b1;
    MEM_WB_En   = 1'b1;
    MD_Start    = 1'b0;
    MD_IsDiv    = 1'b0;
    MD_Busy     = md_busy_q;
    unique case (act)
      ACT_RESET: begin
        PC_En       = 1'b0;
        IF_ID_En    = 1'b0;
        ID_EX_En    = 1'b0;
        EX_MEM_En   = 1'b0;
        MEM_WB_En   = 1'b0;
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
        MD_Busy     = 1'b0;
      end
      ACT_FREEZE: begin
        PC_En     = 1'b0;
        IF_ID_En  = 1'b0;
        ID_EX_En  = 1'b0;
        EX_MEM_En = 1'b0;
        MEM_WB_En = 1'b0;
      end
      ACT_BRANCH: begin
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
      end
      ACT_STALL: begin
        PC_En       = 1'b0;
        IF_ID_En    = 1'b0;
        ID_EX_Flush = 1'b1;
      end
      default: begin
        MD_Start = ID_MDOp;
        MD_IsDiv = ID_MDOp & ID_MDIsDiv;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCnt <= '0;
    end else if (!PC_En && (StallCnt != '1)) begin
      StallCnt <= StallCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, MUL/DIV occupancy, freeze,
// branch priority, mid-operation reset and stall counter saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ID_RAddr1, ID_RAddr2, EX_WAddr;
  logic        ID_Uses1, ID_Uses2, ID_MDOp, ID_MDIsDiv, ID_HiLoRd;
  logic        EX_MemRead, EX_RFWen, EX_BrTaken, MEM_Ready;
  logic        PC_En, IF_ID_En, IF_ID_Flush, ID_EX_En, ID_EX_Flush;
  logic        EX_MEM_En, MEM_WB_En, MD_Start, MD_IsDiv, MD_Busy;
  logic [15:0] StallCnt;

  int n_cmp = 0;
  int n_err = 0;

  // Control word: pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem, memwb, start, isdiv, busy
  logic [9:0] ctl;
  assign ctl = {PC_En, IF_ID_En, IF_ID_Flush, ID_EX_En, ID_EX_Flush,
                EX_MEM_En, MEM_WB_En, MD_Start, MD_IsDiv, MD_Busy};

  localparam logic [9:0] C_RUN   = 10'b1101011000;
  localparam logic [9:0] C_STALL = 10'b0001111000;
  localparam logic [9:0] C_FRZ   = 10'b0000000000;
  localparam logic [9:0] C_BR    = 10'b1111111000;
  localparam logic [9:0] C_RST   = 10'b0010100000;
  localparam logic [9:0] B_BUSY  = 10'b0000000001;
  localparam logic [9:0] B_MUL   = 10'b0000000100;
  localparam logic [9:0] B_DIV   = 10'b0000000110;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ID_RAddr1(ID_RAddr1), .ID_RAddr2(ID_RAddr2),
    .ID_Uses1(ID_Uses1), .ID_Uses2(ID_Uses2),
    .ID_MDOp(ID_MDOp), .ID_MDIsDiv(ID_MDIsDiv), .ID_HiLoRd(ID_HiLoRd),
    .EX_MemRead(EX_MemRead), .EX_RFWen(EX_RFWen), .EX_WAddr(EX_WAddr),
    .EX_BrTaken(EX_BrTaken), .MEM_Ready(MEM_Ready),
    .PC_En(PC_En), .IF_ID_En(IF_ID_En), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_En(ID_EX_En), .ID_EX_Flush(ID_EX_Flush),
    .EX_MEM_En(EX_MEM_En), .MEM_WB_En(MEM_WB_En),
    .MD_Start(MD_Start), .MD_IsDiv(MD_IsDiv), .MD_Busy(MD_Busy),
    .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ID_RAddr1 = '0; ID_RAddr2 = '0; EX_WAddr = '0;
    ID_Uses1 = 0; ID_Uses2 = 0; ID_MDOp = 0; ID_MDIsDiv = 0; ID_HiLoRd = 0;
    EX_MemRead = 0; EX_RFWen = 0; EX_BrTaken = 0; MEM_Ready = 1;
  endtask

  task automatic set_load_use(input logic [4:0] waddr);
    EX_MemRead = 1; EX_RFWen = 1; EX_WAddr = waddr;
    ID_Uses2 = 1; ID_RAddr2 = waddr;
  endtask

  initial begin
    logic [9:0] exp_ctl;
    clear_inputs();
    rst_n = 0;

    // Reset state
    tick(); #1;
    chk("reset_ctl", 32'(ctl), 32'(C_RST));
    chk("reset_scnt", 32'(StallCnt), 32'd0);
    tick();
    rst_n = 1; #1;
    chk("run_idle", 32'(ctl), 32'(C_RUN));

    // Load-use on r5 via RAddr2: exactly one stall cycle
    set_load_use(5'd5); #1;
    chk("lu_stall", 32'(ctl), 32'(C_STALL));
    tick();
    clear_inputs(); #1;
    chk("lu_after", 32'(ctl), 32'(C_RUN));
    chk("lu_scnt", 32'(StallCnt), 32'd1);
    set_load_use(5'd0); #1;
    chk("lu_r0", 32'(ctl), 32'(C_RUN));
    clear_inputs();
    EX_MemRead = 1; EX_RFWen = 1; EX_WAddr = 5'd7; ID_RAddr1 = 5'd7; #1;
    chk("lu_unused_src", 32'(ctl), 32'(C_RUN));
    ID_Uses1 = 1; EX_RFWen = 0; #1;
    chk("lu_no_wen", 32'(ctl), 32'(C_RUN));
    clear_inputs();

    // MULT then MFLO: 4 stall cycles, issues when busy drops
    tick();
    ID_MDOp = 1; #1;
    chk("mul_start", 32'(ctl), 32'(C_RUN | B_MUL));
    tick();
    ID_MDOp = 0; ID_HiLoRd = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mflo_stall%0d", i), 32'(ctl), 32'(C_STALL | B_BUSY));
      tick();
    end
    #1;
    chk("mflo_issue", 32'(ctl), 32'(C_RUN));
    chk("mflo_scnt", 32'(StallCnt), 32'd5);
    clear_inputs();

    // DIV with a 3-cycle memory freeze; pending branch held through freeze
    tick();
    ID_MDOp = 1; ID_MDIsDiv = 1; #1;
    chk("div_start", 32'(ctl), 32'(C_RUN | B_DIV));
    tick();
    clear_inputs();
    for (int k = 1; k <= 13; k++) begin
      MEM_Ready  = !(k >= 3 && k <= 5);
      EX_BrTaken = (k >= 4 && k <= 6);
      #1;
      if (k >= 3 && k <= 5) exp_ctl = C_FRZ;
      else if (k == 6)      exp_ctl = C_BR;
      else                  exp_ctl = C_RUN;
      if (k <= 12) exp_ctl = exp_ctl | B_BUSY;
      chk($sformatf("div_cyc%0d", k), 32'(ctl), 32'(exp_ctl));
      if (k == 6) chk("div_frz_scnt", 32'(StallCnt), 32'd8);
      tick();
    end
    clear_inputs();

    // Branch beats load-use and MD issue; occupancy untouched
    set_load_use(5'd3); ID_MDOp = 1; EX_BrTaken = 1; #1;
    chk("br_prio", 32'(ctl), 32'(C_BR));
    tick();
    clear_inputs(); #1;
    chk("br_no_md", 32'(ctl), 32'(C_RUN));

    // Reset two cycles into a DIV
    ID_MDOp = 1; ID_MDIsDiv = 1; #1;
    chk("div2_start", 32'(ctl), 32'(C_RUN | B_DIV));
    tick();
    clear_inputs();
    tick(); #1;
    chk("div2_busy", 32'(ctl), 32'(C_RUN | B_BUSY));
    rst_n = 0; #1;
    chk("rst_async_ctl", 32'(ctl), 32'(C_RST));
    chk("rst_async_scnt", 32'(StallCnt), 32'd0);
    ID_MDOp = 1;
    tick(); #1;
    chk("rst_hold_ctl", 32'(ctl), 32'(C_RST));
    rst_n = 1; ID_MDOp = 0; #1;
    chk("rst_release", 32'(ctl), 32'(C_RUN));
    tick(); #1;
    chk("rst_scnt_idle", 32'(StallCnt), 32'd0);

    // Stall counter saturation
    set_load_use(5'd9); #1;
    chk("sat_stall", 32'(ctl), 32'(C_STALL));
    for (int i = 0; i < 100; i++) tick();
    chk("sat_mid", 32'(StallCnt), 32'd100);
    for (int i = 100; i < 65541; i++) tick();
    chk("sat_top", 32'(StallCnt), 32'h0000FFFF);
    clear_inputs(); #1;
    chk("sat_run", 32'(ctl), 32'(C_RUN));
    tick();
    chk("sat_hold", 32'(StallCnt), 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
